keycode_action_decoder: RTL and testbench
=========================================

Name: keycode_action_decoder

Overview:
- Consumes the 8-bit USB HID keycode exported by the SoC's keycode PIO and turns it into single-cycle game-action pulses for the Tetris game-logic block.
- Provides press detection plus DAS/ARR auto-repeat (delayed auto-shift, then fixed-rate repeat) for movement and soft drop.
- Sits directly downstream of the SoC keycode export, in the same clock domain.

Parameters:
- DAS_DELAY, 10000000, cycles from the initial press pulse to the first repeat pulse (200 ms at 50 MHz); must be >= 2.
- ARR_PERIOD, 2500000, cycles between successive repeat pulses (50 ms); must be >= 1.
- CNT_W, 24, repeat counter width; must satisfy 2^CNT_W > max(DAS_DELAY, ARR_PERIOD).

Ports:
- clk_clk  input  1  system clock, 50 MHz
- reset_reset_n  input  1  asynchronous active-low reset
- keycode  input  8  current HID keycode from the SoC; 0x00 = no key
- move_left  output  1  one-cycle pulse
- move_right  output  1  one-cycle pulse
- rotate_cw  output  1  one-cycle pulse
- rotate_ccw  output  1  one-cycle pulse
- soft_drop  output  1  one-cycle pulse
- hard_drop  output  1  one-cycle pulse
- pause_toggle  output  1  one-cycle pulse
- held_action  output  3  encoded action currently held, for LEDs; 0 = none

Behaviour:
- Key map (HID codes):
  - 0x04 A -> left (code 1)
  - 0x07 D -> right (2)
  - 0x1A W -> rotate_cw (3)
  - 0x14 Q -> rotate_ccw (4)
  - 0x16 S -> soft_drop (5)
  - 0x2C Space -> hard_drop (6)
  - 0x13 P -> pause_toggle (7)
  - Any other code maps to action 0 (none).
- Registers: key_q[7:0], state, cnt[CNT_W-1:0], all pulse outputs, held_action. All outputs are registered.
- Reset (asynchronous, active-low): key_q=0, state=IDLE, cnt=0, all pulses 0, held_action=0.
- key_q <= keycode every cycle. A "press event" occurs at a clock edge where keycode != key_q and keycode maps to a nonzero action.
- Latency: on a press event at edge k, the mapped pulse is high for exactly the cycle between edges k and k+1.
- At most one pulse output is high in any cycle.
- States:
  - IDLE:
    - On a press event: emit pulse and set held_action.
    - If the action is repeatable (left, right, soft_drop): cnt <= DAS_DELAY-1, go to DELAY.
    - Otherwise go to HOLD.
  - DELAY:
    - cnt decrements each cycle.
    - When cnt==0 with keycode unchanged: emit repeat pulse, cnt <= ARR_PERIOD-1, go to REPEAT.
  - REPEAT:
    - cnt decrements each cycle.
    - When cnt==0 with keycode unchanged: emit pulse, cnt <= ARR_PERIOD-1.
  - HOLD:
    - No further pulses until keycode changes.
- Leaving any non-IDLE state:
  - keycode changes to 0 or an unmapped code: go to IDLE, held_action=0, no pulse.
  - keycode changes to a different mapped code: treated as a new press event (pulse, restart DAS), regardless of current state.
- Timing consequences: the first repeat pulse comes DAS_DELAY cycles after the initial pulse; later repeats are every ARR_PERIOD cycles.
- Simultaneous keycode change and cnt==0: the change wins. No repeat pulse for the old key; the new key's press pulse is emitted if it is mapped.
- Same code re-sampled: never a press event. A release (through 0x00) is required to re-press.
- Reset released while a key is held: key_q=0, so the held key produces a fresh press pulse on the first edge after reset.
- The counter never wraps; it is only loaded or decremented in DELAY/REPEAT.

Optional Feature:
- Macro: ARROW_KEYS_EN.
- When defined, add arrow-key aliases:
  - 0x50 -> left
  - 0x4F -> right
  - 0x52 -> rotate_cw
  - 0x51 -> soft_drop
- Aliases have identical press/repeat behaviour. Switching between an alias and the letter key for the same action counts as a new press.
- When undefined, these codes map to none.

Test Plan (bench with DAS_DELAY=8, ARR_PERIOD=3):
- Reset, then keycode=0x04 held 20 cycles:
  - move_left pulses at cycles 1, 9, 12, 15, 18 after the change.
  - held_action=1 throughout.
  - After keycode=0x00, held_action=0 and no more pulses.
- keycode=0x2C held 30 cycles: exactly one hard_drop pulse; held_action=6; no other outputs.
- keycode=0x04 for 5 cycles, then directly 0x07: one move_left, then move_right on the first cycle after the switch, with DAS restarted (next move_right 8 cycles later).
- keycode 0x04 switched to 0x16 on exactly the cycle the DELAY counter expires: no move_left repeat; a soft_drop pulse that cycle.
- keycode=0x07 held; reset_reset_n asserted mid-REPEAT for 2 cycles, then released:
  - All outputs 0 during reset.
  - move_right pulse on the first edge after release.
- keycode=0x50:
  - With ARROW_KEYS_EN: move_left press and repeat, same as 0x04.
  - Without it: no pulses and held_action=0.

Source files
------------

// File: rtl/keycode_action_decoder.sv
// keycode_action_decoder
//   Turns the 8-bit USB HID keycode from the SoC keycode PIO into one-cycle
//   game-action pulses for the Tetris game-logic block. Left, right and
//   soft drop auto-repeat: the first repeat comes DAS_DELAY cycles after the
//   press pulse, and later repeats follow every ARR_PERIOD cycles.
//
// Optional build macro:
//   ARROW_KEYS_EN - when defined, arrow keys alias the letter keys:
//                   0x50 left, 0x4F right, 0x52 rotate_cw, 0x51 soft_drop.
//
// Ports:
//   clk_clk        in   system clock (50 MHz)
//   reset_reset_n  in   asynchronous active-low reset
//   keycode[7:0]   in   current HID keycode, 0x00 = no key
//   move_left      out  one-cycle pulse
//   move_right     out  one-cycle pulse
//   rotate_cw      out  one-cycle pulse
//   rotate_ccw     out  one-cycle pulse
//   soft_drop      out  one-cycle pulse
//   hard_drop      out  one-cycle pulse
//   pause_toggle   out  one-cycle pulse
//   held_action    out  encoded action currently held (0 = none), for LEDs
module keycode_action_decoder #(
  parameter int DAS_DELAY  = 10000000,
  parameter int ARR_PERIOD = 2500000,
  parameter int CNT_W      = 24
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] keycode,
  output logic       move_left,
  output logic       move_right,
  output logic       rotate_cw,
  output logic       rotate_ccw,
  output logic       soft_drop,
  output logic       hard_drop,
  output logic       pause_toggle,
  output logic [2:0] held_action
);

  localparam logic [2:0] ACT_NONE   = 3'd0;
  localparam logic [2:0] ACT_LEFT   = 3'd1;
  localparam logic [2:0] ACT_RIGHT  = 3'd2;
  localparam logic [2:0] ACT_ROT_CW = 3'd3;
  localparam logic [2:0] ACT_ROT_CC = 3'd4;
  localparam logic [2:0] ACT_SOFT   = 3'd5;
  localparam logic [2:0] ACT_HARD   = 3'd6;
  localparam logic [2:0] ACT_PAUSE  = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    HOLD   = 2'd3
  } state_t;

  function automatic logic [2:0] map_key(input logic [7:0] code);
    case (code)
      8'h04:   map_key = ACT_LEFT;
      8'h07:   map_key = ACT_RIGHT;
      8'h1A:   map_key = ACT_ROT_CW;
      8'h14:   map_key = ACT_ROT_CC;
      8'h16:   map_key = ACT_SOFT;
      8'h2C:   map_key = ACT_HARD;
      8'h13:   map_key = ACT_PAUSE;
`ifdef ARROW_KEYS_EN
      8'h50:   map_key = ACT_LEFT;
      8'h4F:   map_key = ACT_RIGHT;
      8'h52:   map_key = ACT_ROT_CW;
      8'h51:   map_key = ACT_SOFT;
`endif
      default: map_key = ACT_NONE;
    endcase
  endfunction

  function automatic logic is_repeatable(input logic [2:0] act);
    is_repeatable = (act == ACT_LEFT) || (act == ACT_RIGHT) || (act == ACT_SOFT);
  endfunction

  // One-hot pulse vector, bit (act-1) set; bit order matches the pulse ports.
  function automatic logic [6:0] pulse_of(input logic [2:0] act);
    if (act == ACT_NONE) pulse_of = 7'd0;
    else                 pulse_of = 7'd1 << (act - 3'd1);
  endfunction

  logic [7:0]       key_q;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       pulse_q;
  logic             key_changed;
  logic [2:0]       new_act;

  assign key_changed = (keycode != key_q);
  assign new_act     = map_key(keycode);

  assign move_left    = pulse_q[0];
  assign move_right   = pulse_q[1];
  assign rotate_cw    = pulse_q[2];
  assign rotate_ccw   = pulse_q[3];
  assign soft_drop    = pulse_q[4];
  assign hard_drop    = pulse_q[5];
  assign pause_toggle = pulse_q[6];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      key_q       <= 8'd0;
      state       <= IDLE;
      cnt         <= '0;
      pulse_q     <= 7'd0;
      held_action <= ACT_NONE;
    end else begin
      key_q   <= keycode;
      pulse_q <= 7'd0;
      // A keycode change always takes priority over a pending repeat, so a
      // switch landing on the cycle the counter expires never repeats the
      // old key.
      if (key_changed) begin
        if (new_act != ACT_NONE) begin
          pulse_q     <= pulse_of(new_act);
          held_action <= new_act;
          if (is_repeatable(new_act)) begin
            cnt   <= CNT_W'(DAS_DELAY - 1);
            state <= DELAY;
          end else begin
            state <= HOLD;
          end
        end else begin
          state       <= IDLE;
          held_action <= ACT_NONE;
        end
      end else begin
        case (state)
          DELAY, REPEAT: begin
            if (cnt == '0) begin
              pulse_q <= pulse_of(held_action);
              cnt     <= CNT_W'(ARR_PERIOD - 1);
              state   <= REPEAT;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keycode_action_decoder.sv
module tb_keycode_action_decoder;

  localparam int DAS = 8;
  localparam int ARR = 3;

  localparam logic [6:0] P_NONE  = 7'b0000000;
  localparam logic [6:0] P_LEFT  = 7'b0000001;
  localparam logic [6:0] P_RIGHT = 7'b0000010;
  localparam logic [6:0] P_SOFT  = 7'b0010000;
  localparam logic [6:0] P_HARD  = 7'b0100000;

  // Segment modes: no pulse, single press pulse, press plus DAS/ARR repeat.
  localparam int M_NONE = 0;
  localparam int M_ONCE = 1;
  localparam int M_REP  = 2;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       move_left, move_right, rotate_cw, rotate_ccw;
  logic       soft_drop, hard_drop, pause_toggle;
  logic [2:0] held_action;
  logic [9:0] obs;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] stim_kc[$];
  logic       stim_rst[$];
  logic [9:0] sb[$];

  keycode_action_decoder #(
    .DAS_DELAY (DAS),
    .ARR_PERIOD(ARR),
    .CNT_W     (24)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .keycode      (keycode),
    .move_left    (move_left),
    .move_right   (move_right),
    .rotate_cw    (rotate_cw),
    .rotate_ccw   (rotate_ccw),
    .soft_drop    (soft_drop),
    .hard_drop    (hard_drop),
    .pause_toggle (pause_toggle),
    .held_action  (held_action)
  );

  always #5 clk_clk = ~clk_clk;

  assign obs = {held_action, pause_toggle, hard_drop, soft_drop,
                rotate_ccw, rotate_cw, move_right, move_left};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // Queue n edges of stimulus; the expected output after edge i (1-based,
  // counted from the start of the segment) goes to the scoreboard.
  task automatic add_seg(input logic [7:0] kc, input logic rstn, input int n,
                         input int mode, input logic [6:0] p, input logic [2:0] held);
    logic hit;
    for (int i = 1; i <= n; i++) begin
      case (mode)
        M_ONCE:  hit = (i == 1);
        M_REP:   hit = (i == 1) || (i >= 1 + DAS && ((i - 1 - DAS) % ARR) == 0);
        default: hit = 1'b0;
      endcase
      stim_kc.push_back(kc);
      stim_rst.push_back(rstn);
      sb.push_back({held, hit ? p : P_NONE});
    end
  endtask

  task automatic cycle(input logic [7:0] kc, input logic rstn);
    @(negedge clk_clk);
    keycode = kc;
    reset_reset_n = rstn;
    @(posedge clk_clk);
    #1;
  endtask

  task automatic test_reset;
    logic [9:0] e;
    add_seg(8'h04, 1'b0, 3, M_NONE, P_NONE, 3'd0);
    add_seg(8'h00, 1'b1, 3, M_NONE, P_NONE, 3'd0);
    for (int i = 0; stim_kc.size() > 0; i++) begin
      cycle(stim_kc.pop_front(), stim_rst.pop_front());
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL reset step %0d: got %b want %b", i, obs, e); end
    end
  endtask

  task automatic test_left_repeat;
    logic [9:0] e;
    add_seg(8'h04, 1'b1, 20, M_REP, P_LEFT, 3'd1);
    add_seg(8'h00, 1'b1, 4, M_NONE, P_NONE, 3'd0);
    for (int i = 0; stim_kc.size() > 0; i++) begin
      cycle(stim_kc.pop_front(), stim_rst.pop_front());
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL left_repeat step %0d: got %b want %b", i, obs, e); end
    end
  endtask

  task automatic test_hard_drop;
    logic [9:0] e;
    add_seg(8'h2C, 1'b1, 30, M_ONCE, P_HARD, 3'd6);
    add_seg(8'h00, 1'b1, 1, M_NONE, P_NONE, 3'd0);
    add_seg(8'h2C, 1'b1, 3, M_ONCE, P_HARD, 3'd6);
    add_seg(8'h00, 1'b1, 2, M_NONE, P_NONE, 3'd0);
    for (int i = 0; stim_kc.size() > 0; i++) begin
      cycle(stim_kc.pop_front(), stim_rst.pop_front());
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL hard_drop step %0d: got %b want %b", i, obs, e); end
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] e;
    add_seg(8'h04, 1'b1, 5, M_REP, P_LEFT, 3'd1);
    add_seg(8'h07, 1'b1, 12, M_REP, P_RIGHT, 3'd2);
    add_seg(8'h00, 1'b1, 2, M_NONE, P_NONE, 3'd0);
    for (int i = 0; stim_kc.size() > 0; i++) begin
      cycle(stim_kc.pop_front(), stim_rst.pop_front());
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL back_to_back step %0d: got %b want %b", i, obs, e); end
    end
  endtask

  // The switch to S lands on the edge where the left-key DAS counter is zero.
  task automatic test_change_at_expiry;
    logic [9:0] e;
    add_seg(8'h04, 1'b1, DAS, M_REP, P_LEFT, 3'd1);
    add_seg(8'h16, 1'b1, 10, M_REP, P_SOFT, 3'd5);
    add_seg(8'h00, 1'b1, 2, M_NONE, P_NONE, 3'd0);
    for (int i = 0; stim_kc.size() > 0; i++) begin
      cycle(stim_kc.pop_front(), stim_rst.pop_front());
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL change_at_expiry step %0d: got %b want %b", i, obs, e); end
    end
  endtask

  task automatic test_unmapped;
    logic [9:0] e;
    add_seg(8'h05, 1'b1, 3, M_NONE, P_NONE, 3'd0);
    add_seg(8'h04, 1'b1, 4, M_REP, P_LEFT, 3'd1);
    add_seg(8'h05, 1'b1, 2, M_NONE, P_NONE, 3'd0);
    add_seg(8'h04, 1'b1, 2, M_REP, P_LEFT, 3'd1);
    add_seg(8'h00, 1'b1, 2, M_NONE, P_NONE, 3'd0);
    for (int i = 0; stim_kc.size() > 0; i++) begin
      cycle(stim_kc.pop_front(), stim_rst.pop_front());
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL unmapped step %0d: got %b want %b", i, obs, e); end
    end
  endtask

  task automatic test_reset_mid_repeat;
    logic [9:0] e;
    add_seg(8'h07, 1'b1, 11, M_REP, P_RIGHT, 3'd2);
    add_seg(8'h07, 1'b0, 2, M_NONE, P_NONE, 3'd0);
    add_seg(8'h07, 1'b1, 10, M_REP, P_RIGHT, 3'd2);
    add_seg(8'h00, 1'b1, 2, M_NONE, P_NONE, 3'd0);
    for (int i = 0; stim_kc.size() > 0; i++) begin
      cycle(stim_kc.pop_front(), stim_rst.pop_front());
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL reset_mid_repeat step %0d: got %b want %b", i, obs, e); end
    end
  endtask

  task automatic test_arrow;
    logic [9:0] e;
`ifdef ARROW_KEYS_EN
    add_seg(8'h50, 1'b1, 13, M_REP, P_LEFT, 3'd1);
    add_seg(8'h04, 1'b1, 3, M_REP, P_LEFT, 3'd1);
`else
    add_seg(8'h50, 1'b1, 13, M_NONE, P_NONE, 3'd0);
`endif
    add_seg(8'h00, 1'b1, 2, M_NONE, P_NONE, 3'd0);
    for (int i = 0; stim_kc.size() > 0; i++) begin
      cycle(stim_kc.pop_front(), stim_rst.pop_front());
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL arrow step %0d: got %b want %b", i, obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_left_repeat();
    test_hard_drop();
    test_back_to_back();
    test_change_at_expiry();
    test_unmapped();
    test_reset_mid_repeat();
    test_arrow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
